// File: rtl/matrix_transpose_stream_if.sv
// Valid/ready stream bundle for the tile transposer: row-major beats in,
// reordered beats out. The slave modport is the transposer's view.
interface matrix_transpose_stream_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LANES      = 4
);
    localparam int unsigned BW = LANES * DATA_WIDTH;

    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_transpose_stream.sv
// Double-buffered NxN tile transposer. Tiles arrive row-major, LANES
// elements per beat, and leave column-major (mode_i=1) or row-major
// (mode_i=0); the mode is captured on the first beat of each tile.
// Two ping-pong banks let one tile load while the other drains.
// Optional build macro MATRIX_TRANSPOSE_TILE_CNT_EN adds a drained-tile
// counter (tile_cnt) and an input stall flag (ovf_stall).
module matrix_transpose_stream #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N          = 32,
    parameter int unsigned LANES      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode_i,
    matrix_transpose_stream_if.slave     bus,
    output logic                         err
`ifdef MATRIX_TRANSPOSE_TILE_CNT_EN
    ,
    output logic [31:0]                  tile_cnt,
    output logic                         ovf_stall
`endif
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned ELEMS = N * N;
    localparam int unsigned BEATS = ELEMS / LANES;
    localparam int unsigned BPR   = N / LANES;       // beats per row
    localparam int unsigned CW    = $clog2(BEATS);
    localparam int unsigned AW    = $clog2(ELEMS);

    // Bank storage; contents survive reset, only the bookkeeping is cleared.
    logic [DW-1:0] mem_q [2][ELEMS];

    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          err_q, err_d;

    logic          in_fire_c;
    logic          out_fire_c;
    logic          wr_last_c;
    logic          rd_last_c;
    logic [AW-1:0] wr_addr_c [LANES];
    logic [AW-1:0] rd_addr_c [LANES];

    // Handshake status, all derived directly from flops.
    assign bus.in_ready  = ~full_q[wr_sel_q];
    assign bus.out_valid = full_q[rd_sel_q];
    assign wr_last_c     = (wr_cnt_q == CW'(BEATS - 1));
    assign rd_last_c     = (rd_cnt_q == CW'(BEATS - 1));
    assign bus.out_last  = bus.out_valid && rd_last_c;
    assign in_fire_c     = bus.in_valid && bus.in_ready;
    assign out_fire_c    = bus.out_valid && bus.out_ready;
    assign err           = err_q;

    // Write addresses: beat k covers row-major elements k*LANES .. k*LANES+LANES-1.
    always_comb begin : wr_addr_gen
        for (int unsigned l = 0; l < LANES; l++) begin
            wr_addr_c[l] = AW'(32'(wr_cnt_q) * LANES + l);
        end
    end

    // Read addresses: transpose walks columns, LANES rows per beat; pass mirrors the input order.
    always_comb begin : rd_addr_gen
        for (int unsigned l = 0; l < LANES; l++) begin
            if (mode_q[rd_sel_q]) begin
                rd_addr_c[l] = AW'(((32'(rd_cnt_q) % BPR) * LANES + l) * N
                                   + 32'(rd_cnt_q) / BPR);
            end else begin
                rd_addr_c[l] = AW'(32'(rd_cnt_q) * LANES + l);
            end
        end
    end

    // Combinational read of the draining bank.
    always_comb begin : rd_data_mux
        bus.out_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            bus.out_data[l*DW +: DW] = mem_q[rd_sel_q][rd_addr_c[l]];
        end
    end

    // Bank write port; only a non-full bank is ever written.
    always_ff @(posedge clk) begin
        if (in_fire_c) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                mem_q[wr_sel_q][wr_addr_c[l]] <= bus.in_data[l*DW +: DW];
            end
        end
    end

    // Next-state for pointers, counters, flags. Fill and drain always touch
    // different banks, so their updates to full_d never collide.
    always_comb begin : ctrl_next
        full_d   = full_q;
        mode_d   = mode_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = err_q;

        if (in_fire_c) begin
            if (wr_cnt_q == '0) begin
                mode_d[wr_sel_q] = mode_i;
            end
            // Framing is judged against the counter; in_last never realigns it.
            if (bus.in_last != wr_last_c) begin
                err_d = 1'b1;
            end
            if (wr_last_c) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                wr_cnt_d         = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end

        if (out_fire_c) begin
            if (rd_last_c) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
                rd_cnt_d         = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q   <= '0;
            mode_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            mode_q   <= mode_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef MATRIX_TRANSPOSE_TILE_CNT_EN
    logic [31:0] tile_cnt_q, tile_cnt_d;

    // Count drained tiles, wrapping naturally at 2^32.
    always_comb begin : tile_cnt_next
        tile_cnt_d = tile_cnt_q;
        if (out_fire_c && rd_last_c) begin
            tile_cnt_d = tile_cnt_q + 32'(1);
        end
    end

    // Tile counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt_q <= '0;
        end else begin
            tile_cnt_q <= tile_cnt_d;
        end
    end

    assign tile_cnt  = tile_cnt_q;
    assign ovf_stall = bus.in_valid && !bus.in_ready;
`endif

    // A stalled output beat must not change underneath the sink.
    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last)));

    // Fill and drain never target the same bank in one cycle.
    a_bank_excl: assert property (@(posedge clk) disable iff (!rst)
        !(in_fire_c && out_fire_c && (wr_sel_q == rd_sel_q)));

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Bench for matrix_transpose_stream: a LANES=1 instance checked from a
// vector table, and a LANES=2 instance driven through a scoreboard that
// also checks backpressure, ping-pong, framing errors and async reset.
module tb_matrix_transpose_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mode_a, mode_b;
    logic err_a, err_b;

    matrix_transpose_stream_if #(.DATA_WIDTH(16), .LANES(1)) ifa ();
    matrix_transpose_stream_if #(.DATA_WIDTH(16), .LANES(2)) ifb ();

`ifdef MATRIX_TRANSPOSE_TILE_CNT_EN
    logic [31:0] tc_a, tc_b;
    logic        ovf_a, ovf_b;
`endif

    matrix_transpose_stream #(.DATA_WIDTH(16), .N(4), .LANES(1)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_a),
        .bus    (ifa.slave),
        .err    (err_a)
`ifdef MATRIX_TRANSPOSE_TILE_CNT_EN
        ,
        .tile_cnt  (tc_a),
        .ovf_stall (ovf_a)
`endif
    );

    matrix_transpose_stream #(.DATA_WIDTH(16), .N(4), .LANES(2)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_b),
        .bus    (ifb.slave),
        .err    (err_b)
`ifdef MATRIX_TRANSPOSE_TILE_CNT_EN
        ,
        .tile_cnt  (tc_b),
        .ovf_stall (ovf_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Sink ready for dut_b: fixed, or randomised every cycle.
    logic rdy_b, rand_en, rnd_rdy;
    assign ifb.out_ready = rand_en ? rnd_rdy : rdy_b;
    always @(posedge clk) begin
        #1 rnd_rdy = 1'($urandom_range(0, 1));
    end

    // Vector tables.
    typedef struct {
        logic [15:0] din;
        logic        din_last;
        logic [15:0] dout;
        logic        dout_last;
    } vec_a_t;
    vec_a_t va[16];
    int exp_tr_a[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    logic [31:0] in_b[8]  = '{32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006,
                              32'h0009_0008, 32'h000B_000A, 32'h000D_000C, 32'h000F_000E};
    logic [31:0] tr_b[8]  = '{32'h0004_0000, 32'h000C_0008, 32'h0005_0001, 32'h000D_0009,
                              32'h0006_0002, 32'h000E_000A, 32'h0007_0003, 32'h000F_000B};

    // Scoreboard for dut_b.
    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;
    exp_t sbq[$];
    exp_t e_mon;

    // Expected dut_b beat k for a tile whose element [r][c] = base + 4r + c.
    function automatic logic [31:0] model_b(logic m, logic [15:0] base, int k);
        logic [15:0] e0, e1;
        int c, r0;
        if (m) begin
            c  = k / 2;
            r0 = (k % 2) * 2;
            e0 = base + 16'(r0 * 4 + c);
            e1 = base + 16'((r0 + 1) * 4 + c);
        end else begin
            e0 = base + 16'(2 * k);
            e1 = base + 16'(2 * k + 1);
        end
        return {e1, e0};
    endfunction

    // Drive one beat into dut_b; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send_beat_b(input logic [31:0] d, input logic last, input logic m);
        int t;
        ifb.in_valid = 1'b1;
        ifb.in_data  = d;
        ifb.in_last  = last;
        mode_b       = m;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ifb.in_ready && t < 400);
        if (!ifb.in_ready) begin
            total++;
            bad++;
            $display("FAIL in_timeout: in_ready stuck at 0 for %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
    endtask

    task automatic send_tile_b(input logic m, input logic [15:0] base, input int bad_last);
        for (int k = 0; k < 8; k++) begin
            send_beat_b({base + 16'(2 * k + 1), base + 16'(2 * k)},
                        (bad_last >= 0) ? (k == bad_last) : (k == 7), m);
        end
        for (int k = 0; k < 8; k++) begin
            sbq.push_back('{d: model_b(m, base, k), l: (k == 7)});
        end
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while ((sbq.size() != 0 || ifb.out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(sbq.size()), 64'(0));
    endtask

    // dut_b monitor: scoreboard, stall stability, accept count, ready-return check.
    logic [31:0] held_d;
    logic        held_l;
    bit          hold = 0;
    int          acc_b = 0;
    bit          watch_ir = 0, ir_pend = 0, ir_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            hold    = 0;
            ir_pend = 0;
        end else begin
            if (ir_pend) begin
                chk("ir_return", 64'(ifb.in_ready), 64'(1));
                ir_pend = 0;
                ir_done = 1;
            end
            if (ifb.in_valid && ifb.in_ready) acc_b++;
            if (ifb.out_valid) begin
                if (hold) begin
                    chk("stable_data", 64'(ifb.out_data), 64'(held_d));
                    chk("stable_last", 64'(ifb.out_last), 64'(held_l));
                end
                if (ifb.out_ready) begin
                    hold = 0;
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: got beat %0h, required no beat", ifb.out_data);
                    end else begin
                        e_mon = sbq.pop_front();
                        chk("b_data", 64'(ifb.out_data), 64'(e_mon.d));
                        chk("b_last", 64'(ifb.out_last), 64'(e_mon.l));
                    end
                    if (ifb.out_last && watch_ir) begin
                        chk("ir_low_at_last", 64'(ifb.in_ready), 64'(0));
                        watch_ir = 0;
                        ir_pend  = 1;
                    end
                end else begin
                    hold   = 1;
                    held_d = ifb.out_data;
                    held_l = ifb.out_last;
                end
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    bit sent_done = 0;

    initial begin
        int t;
        rst           = 1'b0;
        mode_a        = 1'b0;
        mode_b        = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.in_last   = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.in_valid  = 1'b0;
        ifb.in_data   = '0;
        ifb.in_last   = 1'b0;
        rdy_b         = 1'b1;
        rand_en       = 1'b0;

        for (int i = 0; i < 16; i++) begin
            va[i].din       = 16'(i);
            va[i].din_last  = (i == 15);
            va[i].dout      = 16'(exp_tr_a[i]);
            va[i].dout_last = (i == 15);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_in_ready",  64'(ifa.in_ready),  64'(1));
        chk("rst_a_out_valid", 64'(ifa.out_valid), 64'(0));
        chk("rst_a_err",       64'(err_a),         64'(0));
        chk("rst_b_in_ready",  64'(ifb.in_ready),  64'(1));
        chk("rst_b_out_valid", 64'(ifb.out_valid), 64'(0));
        chk("rst_b_out_last",  64'(ifb.out_last),  64'(0));
        chk("rst_b_err",       64'(err_b),         64'(0));
        rst = 1'b1;

        // LANES=1 transpose from the vector table, with first-output latency.
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = va[i].din;
            ifa.in_last  = va[i].din_last;
            mode_a       = 1'b1;
            @(negedge clk);
            if (i == 15) chk("a_lat_pre", 64'(ifa.out_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
        @(negedge clk);
        chk("a_lat_first", 64'(ifa.out_valid), 64'(1));
        for (int i = 0; i < 16; i++) begin
            t = 0;
            while (!ifa.out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("a_data", 64'(ifa.out_data), 64'(va[i].dout));
            chk("a_last", 64'(ifa.out_last), 64'(va[i].dout_last));
            @(negedge clk);
        end
        chk("a_idle", 64'(ifa.out_valid), 64'(0));
        chk("a_err", 64'(err_a), 64'(0));

        // LANES=2 pass then transpose from tables, back to back.
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) sbq.push_back('{d: in_b[k], l: (k == 7)});
        for (int k = 0; k < 8; k++) send_beat_b(in_b[k], (k == 7), 1'b0);
        for (int k = 0; k < 8; k++) sbq.push_back('{d: tr_b[k], l: (k == 7)});
        for (int k = 0; k < 8; k++) send_beat_b(in_b[k], (k == 7), 1'b1);
        wait_empty();

        // Mixed modes back to back.
        @(posedge clk);
        #1;
        send_tile_b(1'b1, 16'h0100, -1);
        send_tile_b(1'b0, 16'h0200, -1);
        send_tile_b(1'b1, 16'h0300, -1);
        wait_empty();
        chk("err_clean", 64'(err_b), 64'(0));

        // Backpressure: both banks fill, third tile stalls until a drain completes.
        @(posedge clk);
        #1;
        rdy_b     = 1'b0;
        acc_b     = 0;
        sent_done = 0;
        fork
            begin
                send_tile_b(1'b1, 16'h1000, -1);
                send_tile_b(1'b0, 16'h2000, -1);
                send_tile_b(1'b1, 16'h3000, -1);
                sent_done = 1;
            end
        join_none
        t = 0;
        while (acc_b < 16 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        chk("acc_hold",  64'(acc_b),         64'(16));
        chk("ir_drop",   64'(ifb.in_ready),  64'(0));
        chk("ov_hold",   64'(ifb.out_valid), 64'(1));
        @(posedge clk);
        #1;
        watch_ir = 1;
        rdy_b    = 1'b1;
        t = 0;
        while (!ir_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ir_seen", 64'(ir_done), 64'(1));
        rand_en = 1'b1;
        t = 0;
        while (!sent_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("bp_sent", 64'(sent_done), 64'(1));
        @(posedge clk);
        #1;
        send_tile_b(1'b0, 16'h4000, -1);
        send_tile_b(1'b1, 16'h5000, -1);
        wait_empty();
        rand_en = 1'b0;

        // Early in_last on beat 5: sticky error, tile framing unchanged.
        @(posedge clk);
        #1;
        send_tile_b(1'b1, 16'h6000, 5);
        @(negedge clk);
        chk("err_set", 64'(err_b), 64'(1));
        wait_empty();
        @(posedge clk);
        #1;
        send_tile_b(1'b0, 16'h7000, -1);
        wait_empty();
        chk("err_sticky", 64'(err_b), 64'(1));

        // Async reset in the middle of a drain.
        @(posedge clk);
        #1;
        rdy_b = 1'b0;
        send_tile_b(1'b1, 16'h8000, -1);
        rdy_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(ifb.out_valid), 64'(0));
        chk("mid_rst_out_last",  64'(ifb.out_last),  64'(0));
        chk("mid_rst_in_ready",  64'(ifb.in_ready),  64'(1));
        chk("mid_rst_err",       64'(err_b),         64'(0));
        sbq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_tile_b(1'b1, 16'h9000, -1);
        wait_empty();
        chk("post_rst_err", 64'(err_b), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
